uart_rx_byte: RTL and testbench
===============================

// Module: uart_rx_byte
// PURPOSE
//  UART receiver: 8N1 async serial on iRx_serial -> parallel bytes + 1-cycle strobe.
//  Inbound counterpart of the PE FPGA UART transmitter; sits in PE_FPGA_top between the
//  iRx_serial pin and the byte consumer (command/memory load logic).
//  Mid-bit sampling; rejects start-bit glitches; flags framing errors.
// PARAMETERS
//  CLK_FREQ      50_000_000   system clock frequency, Hz
//  BAUD          115200       serial bit rate, bits/s
//  CLKS_PER_BIT  CLK_FREQ/BAUD  clocks per bit (integer, >= 8); derived, not overridden
//  DATA_BITS     8            payload bits per frame, LSB first (5..8)
// PORTS
//  clk          in   1          system clock, all logic on rising edge
//  rst_n        in   1          asynchronous reset, active-low
//  iRx_serial   in   1          async serial line, idle high
//  o_data       out  DATA_BITS  last received byte, stable until next frame ends
//  o_valid      out  1          1-cycle strobe: o_data holds a good frame
//  o_frame_err  out  1          1-cycle strobe: stop bit sampled low
//  o_busy       out  1          high from start-bit detect until return to IDLE
// BEHAVIOUR
//  Reset: o_data=0, o_valid=0, o_frame_err=0, o_busy=0, FSM=IDLE; sync flops preset to 1.
//  Input: 2-FF synchronizer on iRx_serial; FSM sees only synchronized rx_s.
//  Counter clk_cnt (0..CLKS_PER_BIT-1), bit index bit_idx (0..DATA_BITS-1).
//  IDLE  : rx_s==0 -> START, clk_cnt=0, o_busy=1.
//  START : at clk_cnt==CLKS_PER_BIT/2-1: rx_s==0 -> DATA, clk_cnt=0, bit_idx=0;
//          rx_s==1 -> glitch, back to IDLE, o_busy=0, no strobe.
//  DATA  : at clk_cnt==CLKS_PER_BIT-1 sample rx_s into shift[bit_idx], clk_cnt=0;
//          after bit DATA_BITS-1 -> PARITY (if enabled) else STOP.
//  STOP  : at clk_cnt==CLKS_PER_BIT-1 sample rx_s:
//          1 -> o_data<=shift, o_valid=1 next cycle, -> IDLE (o_busy=0 same cycle);
//          0 -> o_data unchanged, o_frame_err=1 next cycle, -> BREAK.
//  BREAK : wait for rx_s==1 (line held low/break), then IDLE; no further strobes meanwhile.
//  Latency: strobe asserts 3 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT clocks after the
//   pin's falling edge (+CLKS_PER_BIT with parity); exactly one of o_valid/o_frame_err per frame.
//  Back-to-back: new start bit detected in IDLE the cycle after STOP exits; no lost frame
//   with stop bit of nominal length and <=2% baud mismatch.
//  No backpressure: consumer must take o_data on o_valid; next frame overwrites it.
//  Reset mid-frame: immediate return to IDLE, partial byte discarded, no strobe.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: frame is 8E1; PARITY state samples 1 bit after data;
//   extra output o_parity_err (1 bit, reset 0) pulses with o_valid when received bit !=
//   ^shift; o_data still updated. Stop-bit rules unchanged.
//  Undefined: 8N1 only, no PARITY state, no o_parity_err port.
// TESTING (bench: CLK_FREQ=1_000_000, BAUD=100_000 -> CLKS_PER_BIT=10)
//  1 rst_n=0 with line idle -> all outputs 0; release, 200 clk idle -> no strobe, o_busy=0.
//  2 send 0xA5 8N1 -> single o_valid pulse, o_data=0xA5, at 3+5+90 clk after falling edge.
//  3 send 0x00 then 0xFF back-to-back (1 stop bit) -> two o_valid pulses, data 0x00, 0xFF.
//  4 low glitch 3 clk on idle line -> o_busy pulses, no o_valid/o_frame_err, FSM back to IDLE.
//  5 send 0x3C with stop bit 0, hold low 200 clk -> one o_frame_err, no o_valid, o_data
//    unchanged; after line high, 0x5A -> o_valid, o_data=0x5A.
//  6 rst_n low during bit 4 of 0x81, then send 0x42 -> no strobe for 0x81; o_data=0x42;
//    with UART_RX_PARITY_EN: 0x07 with parity 0 -> o_valid + o_parity_err, o_data=0x07.

Source files
------------

// File: rtl/uart_rx_byte_if.sv
// uart_rx_byte_if: parallel-side bundle of the UART byte receiver.
//   o_data       received byte, held until the next good frame
//   o_valid      1-cycle strobe, o_data holds a good frame
//   o_frame_err  1-cycle strobe, stop bit sampled low
//   o_busy       high while a frame is in progress (start detect .. back in IDLE)
//   o_parity_err 1-cycle strobe with o_valid on even-parity mismatch
//                (present only when UART_RX_PARITY_EN is defined)
// Modports: master = receiver (drives), slave = byte consumer (reads).
interface uart_rx_byte_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] o_data;
  logic                 o_valid;
  logic                 o_frame_err;
  logic                 o_busy;
`ifdef UART_RX_PARITY_EN
  logic                 o_parity_err;
`endif

  modport master (
    output o_data,
    output o_valid,
    output o_frame_err,
`ifdef UART_RX_PARITY_EN
    output o_parity_err,
`endif
    output o_busy
  );

  modport slave (
    input o_data,
    input o_valid,
    input o_frame_err,
`ifdef UART_RX_PARITY_EN
    input o_parity_err,
`endif
    input o_busy
  );
endinterface

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: UART receiver, async serial line -> parallel byte + 1-cycle strobe.
// Frame is 8N1 by default; defining UART_RX_PARITY_EN makes it 8E1 and adds
// o_parity_err to the interface. Mid-bit sampling, start-bit glitch rejection,
// framing-error detection with a break wait until the line returns high.
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous reset, active-low
//   iRx_serial  async serial input, idle high
//   rx_o        uart_rx_byte_if.master: o_data, o_valid, o_frame_err, o_busy
//               (+ o_parity_err with UART_RX_PARITY_EN)
module uart_rx_byte #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iRx_serial,
  uart_rx_byte_if.master   rx_o
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W        = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BREAK
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, BREAK
  } state_e;
`endif

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit_q, par_bit_d;
  logic                 parity_err_q, parity_err_d;
`endif

  // Two-flop synchronizer; preset to idle-high so reset never looks like a start bit
  logic sync1_q, sync2_q;
  logic rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= iRx_serial;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      clk_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Next-state and output logic. The start bit is confirmed at half a bit,
  // so every later sample taken one full bit on lands mid-bit.
  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d    = par_bit_q;
    parity_err_d = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        if (!rx_s) begin
          state_d = START;
        end
      end

      START: begin
        if (clk_cnt_q == CNT_HALF) begin
          clk_cnt_d = '0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            // Line went back high before mid-start: treat as a glitch
            state_d = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          par_bit_d = rx_s;
          state_d   = STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
`endif

      STOP: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            // Even parity: received bit must equal XOR of the data bits
            parity_err_d = par_bit_q ^ (^shift_q);
`endif
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      BREAK: begin
        // Line held low after a bad stop bit: wait for it to return idle
        clk_cnt_d = '0;
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign rx_o.o_data      = data_q;
  assign rx_o.o_valid     = valid_q;
  assign rx_o.o_frame_err = frame_err_q;
  assign rx_o.o_busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign rx_o.o_parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: directed bench for uart_rx_byte at 10 clocks per bit.
module tb_uart_rx_byte;

  localparam int CPB = 10;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 3 + CPB / 2 + 10 * CPB;
`else
  localparam int LAT = 3 + CPB / 2 + 9 * CPB;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b1;

  uart_rx_byte_if #(.DATA_BITS(8)) bus ();

  uart_rx_byte #(
    .CLK_FREQ  (1_000_000),
    .BAUD      (100_000),
    .DATA_BITS (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .iRx_serial (rx),
    .rx_o       (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Strobe monitor, sampled on the falling edge
  int          vcnt = 0, fcnt = 0, pcnt = 0, both = 0;
  int          vcyc = 0, fcyc = 0;
  logic [7:0]  last_d = 8'h00, prev_d = 8'h00;
  bit          busy_seen = 1'b0;

  always @(negedge clk) begin
    if (bus.o_valid) begin
      vcnt++;
      vcyc   = cyc;
      prev_d = last_d;
      last_d = bus.o_data;
    end
    if (bus.o_frame_err) begin
      fcnt++;
      fcyc = cyc;
    end
    if (bus.o_valid && bus.o_frame_err) both++;
`ifdef UART_RX_PARITY_EN
    if (bus.o_parity_err) pcnt++;
`endif
    if (bus.o_busy) busy_seen = 1'b1;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic line(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  int fall_cyc = 0;

  task automatic send(input logic [7:0] d, input logic par, input logic stopb);
    fall_cyc = cyc;
    line(1'b0, CPB);
    for (int i = 0; i < 8; i++) line(d[i], CPB);
`ifdef UART_RX_PARITY_EN
    line(par, CPB);
`else
    if (par) begin end
`endif
    line(stopb, CPB);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stopb;
    int         exp_v;
    int         exp_f;
    logic [7:0] exp_d;
  } vec_t;

  vec_t vt[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int v0, f0, p0;

    vt[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vt[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vt[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vt[3] = '{8'h3C, 1'b0, 0, 1, 8'hFF};
    vt[4] = '{8'h5A, 1'b1, 1, 0, 8'h5A};
    vt[5] = '{8'h81, 1'b1, 1, 0, 8'h81};

    // Reset with idle line
    repeat (3) @(negedge clk);
    chk("reset_data",  int'(bus.o_data), 0);
    chk("reset_valid", int'(bus.o_valid), 0);
    chk("reset_ferr",  int'(bus.o_frame_err), 0);
    chk("reset_busy",  int'(bus.o_busy), 0);
    rst_n = 1'b1;
    line(1'b1, 200);
    chk("idle_valid_cnt", vcnt, 0);
    chk("idle_ferr_cnt",  fcnt, 0);
    chk("idle_busy_seen", int'(busy_seen), 0);

    // Table-driven single frames
    for (int i = 0; i < 6; i++) begin
      v0 = vcnt; f0 = fcnt; p0 = pcnt;
      send(vt[i].d, ^vt[i].d, vt[i].stopb);
      line(1'b1, 30);
      chk($sformatf("vec%0d_valid", i), vcnt - v0, vt[i].exp_v);
      chk($sformatf("vec%0d_ferr", i),  fcnt - f0, vt[i].exp_f);
      chk($sformatf("vec%0d_data", i),  int'(bus.o_data), int'(vt[i].exp_d));
      if (vt[i].exp_v != 0) chk($sformatf("vec%0d_latency", i), vcyc - fall_cyc, LAT);
      else                  chk($sformatf("vec%0d_latency", i), fcyc - fall_cyc, LAT);
      chk($sformatf("vec%0d_busy", i), int'(bus.o_busy), 0);
`ifdef UART_RX_PARITY_EN
      chk($sformatf("vec%0d_perr", i), pcnt - p0, 0);
`endif
    end

    // Back-to-back 0x00 then 0xFF with one nominal stop bit
    v0 = vcnt;
    send(8'h00, 1'b0, 1'b1);
    send(8'hFF, 1'b0, 1'b1);
    line(1'b1, 30);
    chk("b2b_count",   vcnt - v0, 2);
    chk("b2b_first",   int'(prev_d), 8'h00);
    chk("b2b_second",  int'(last_d), 8'hFF);
    chk("b2b_latency", vcyc - fall_cyc, LAT);

    // Three-clock low glitch on an idle line
    v0 = vcnt; f0 = fcnt; busy_seen = 1'b0;
    line(1'b0, 3);
    line(1'b1, 30);
    chk("glitch_busy_seen", int'(busy_seen), 1);
    chk("glitch_valid",     vcnt - v0, 0);
    chk("glitch_ferr",      fcnt - f0, 0);
    chk("glitch_busy_end",  int'(bus.o_busy), 0);

    // Reset during bit 4 of 0x81, then 0x42
    v0 = vcnt; f0 = fcnt;
    line(1'b0, CPB);
    line(1'b1, CPB);
    line(1'b0, CPB);
    line(1'b0, CPB);
    line(1'b0, CPB);
    line(1'b0, CPB / 2);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_data", int'(bus.o_data), 0);
    chk("midrst_busy", int'(bus.o_busy), 0);
    rx    = 1'b1;
    rst_n = 1'b1;
    line(1'b1, 40);
    chk("midrst_no_valid", vcnt - v0, 0);
    chk("midrst_no_ferr",  fcnt - f0, 0);
    send(8'h42, 1'b0, 1'b1);
    line(1'b1, 30);
    chk("after_rst_valid", vcnt - v0, 1);
    chk("after_rst_data",  int'(bus.o_data), 8'h42);

    // Framing error followed by a long break, then a good frame
    v0 = vcnt; f0 = fcnt;
    send(8'h3C, 1'b0, 1'b0);
    line(1'b0, 200);
    chk("break_ferr",  fcnt - f0, 1);
    chk("break_valid", vcnt - v0, 0);
    chk("break_busy",  int'(bus.o_busy), 1);
    chk("break_data",  int'(bus.o_data), 8'h42);
    line(1'b1, 30);
    chk("break_end_busy", int'(bus.o_busy), 0);
    chk("break_one_ferr", fcnt - f0, 1);
    send(8'h5A, 1'b0, 1'b1);
    line(1'b1, 30);
    chk("post_break_valid", vcnt - v0, 1);
    chk("post_break_data",  int'(bus.o_data), 8'h5A);

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight; sending parity 0 must flag an error
    v0 = vcnt; p0 = pcnt;
    send(8'h07, 1'b0, 1'b1);
    line(1'b1, 30);
    chk("par_valid", vcnt - v0, 1);
    chk("par_err",   pcnt - p0, 1);
    chk("par_data",  int'(bus.o_data), 8'h07);
`endif

    chk("never_both_strobes", both, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
